ooo_mem_arbiter: RTL and testbench

Two-to-one memory arbiter that sits directly below the `ooo` core. It merges the core's instruction-fetch port and its load/store data port onto a single downstream memory port (cache or memory model). Requests from both clients are latched into registered downstream signals. Exactly one transaction is outstanding at a time, and each response is routed back to the client that was granted.

---
 rtl/ooo_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_ooo_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ooo_mem_arbiter.sv
// ooo_mem_arbiter: merges the core's fetch and load/store ports onto one
// registered downstream memory port, with one transaction outstanding.
//
// Ports:
//   clk, rst (async, active-low)
//   instr_*  : fetch client (read, address -> resp, rdata)
//   data_*   : load/store client (read/write, mbe, address, wdata -> resp, rdata)
//   mem_*    : downstream port; request side registered, mem_resp/mem_rdata in
//   instr_grants, data_grants : wrapping completed-transaction counters
//
// Build option:
//   OOO_MEM_ARB_RR_EN : round-robin on simultaneous requests
//                       (default: data always wins)

module ooo_mem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_read,
  input  logic [WIDTH-1:0]   instr_mem_address,
  output logic               instr_mem_resp,
  output logic [WIDTH-1:0]   instr_mem_rdata,
  input  logic               data_read,
  input  logic               data_write,
  input  logic [WIDTH/8-1:0] data_mbe,
  input  logic [WIDTH-1:0]   data_mem_address,
  input  logic [WIDTH-1:0]   data_mem_wdata,
  output logic               data_mem_resp,
  output logic [WIDTH-1:0]   data_mem_rdata,
  output logic               mem_read,
  output logic               mem_write,
  output logic [WIDTH/8-1:0] mem_byte_enable,
  output logic [WIDTH-1:0]   mem_address,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic               mem_resp,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [31:0]        instr_grants,
  output logic [31:0]        data_grants
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_last_data;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [WIDTH/8-1:0] r_mem_be;
  logic [WIDTH-1:0]   r_mem_addr;
  logic [WIDTH-1:0]   r_mem_wdata;
  logic [31:0]        r_instr_grants;
  logic [31:0]        r_data_grants;

  logic w_ireq;
  logic w_dreq;
  logic w_pick_data;

  assign w_ireq = instr_read;
  assign w_dreq = data_read | data_write;

`ifdef OOO_MEM_ARB_RR_EN
  // On a tie, serve whichever client did not go last.
  assign w_pick_data = w_dreq & (~w_ireq | ~r_last_data);
`else
  // Data beats fetch so loads/stores drain ahead of speculative fetches.
  assign w_pick_data = w_dreq;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_last_data    <= 1'b0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_be       <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_instr_grants <= '0;
      r_data_grants  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_data) begin
            r_state     <= DATA;
            r_mem_read  <= data_read;
            r_mem_write <= data_write;
            r_mem_be    <= data_mbe;
            r_mem_addr  <= data_mem_address;
            r_mem_wdata <= data_mem_wdata;
          end else if (w_ireq) begin
            r_state     <= INSTR;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
            r_mem_be    <= '1;
            r_mem_addr  <= instr_mem_address;
          end
        end
        INSTR, DATA: begin
          // Transaction cannot be aborted; hold until memory completes.
          if (mem_resp) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_last_data <= (r_state == DATA);
            if (r_state == DATA)
              r_data_grants <= r_data_grants + 32'd1;
            else
              r_instr_grants <= r_instr_grants + 32'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Responses are suppressed to a client that dropped its request.
  assign instr_mem_resp = mem_resp & (r_state == INSTR) & instr_read;
  assign data_mem_resp  = mem_resp & (r_state == DATA) & w_dreq;
  assign instr_mem_rdata = mem_rdata;
  assign data_mem_rdata  = mem_rdata;

  assign mem_read        = r_mem_read;
  assign mem_write       = r_mem_write;
  assign mem_byte_enable = r_mem_be;
  assign mem_address     = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign instr_grants    = r_instr_grants;
  assign data_grants     = r_data_grants;

endmodule

// File: tb/tb_ooo_mem_arbiter.sv
// tb_ooo_mem_arbiter: scoreboard bench for ooo_mem_arbiter.
// Client tasks push expected rdata; a negedge monitor pops on responses.

module tb_ooo_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        instr_mem_resp;
  logic [31:0] instr_mem_rdata;
  logic        data_read;
  logic        data_write;
  logic [3:0]  data_mbe;
  logic [31:0] data_mem_address;
  logic [31:0] data_mem_wdata;
  logic        data_mem_resp;
  logic [31:0] data_mem_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic [31:0] instr_grants;
  logic [31:0] data_grants;

  always #5 clk = ~clk;

  ooo_mem_arbiter #(.WIDTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .data_read         (data_read),
    .data_write        (data_write),
    .data_mbe          (data_mbe),
    .data_mem_address  (data_mem_address),
    .data_mem_wdata    (data_mem_wdata),
    .data_mem_resp     (data_mem_resp),
    .data_mem_rdata    (data_mem_rdata),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_byte_enable   (mem_byte_enable),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_resp          (mem_resp),
    .mem_rdata         (mem_rdata),
    .instr_grants      (instr_grants),
    .data_grants       (data_grants)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_ig = 0;
  int exp_dg = 0;
  logic [31:0] iq[$];
  logic [31:0] dq[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("excl_rw", 32'(mem_read & mem_write), 0);
      chk("excl_resp", 32'(instr_mem_resp & data_mem_resp), 0);
      if (instr_mem_resp) begin
        if (iq.size() == 0) chk("i_unexpected", 1, 0);
        else chk("i_rdata", instr_mem_rdata, iq.pop_front());
      end
      if (data_mem_resp) begin
        if (dq.size() == 0) chk("d_unexpected", 1, 0);
        else chk("d_rdata", data_mem_rdata, dq.pop_front());
      end
    end
  end

  // Memory model: wait for a downstream request, check it, respond.
  task automatic serve(input int lat, input logic [31:0] rdata,
                       input logic rd, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output int t_det, output int t_resp,
                       output logic got_i, output logic got_d);
    int n;
    n = 0; t_det = 0; t_resp = 0; got_i = 0; got_d = 0;
    while (!(mem_read | mem_write) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk("serve_timeout", 1, 0);
      return;
    end
    t_det = cyc;
    chk("mem_read", 32'(mem_read), 32'(rd));
    chk("mem_write", 32'(mem_write), 32'(!rd));
    chk("mem_addr", mem_address, addr);
    chk("mem_be", 32'(mem_byte_enable), 32'(be));
    if (!rd) chk("mem_wdata", mem_wdata, wd);
    repeat (lat - 1) begin
      @(posedge clk); #1;
      chk("hold_addr", mem_address, addr);
      chk("hold_req", 32'(mem_read), 32'(rd));
    end
    mem_resp = 1'b1;
    mem_rdata = rdata;
    t_resp = cyc;
    @(negedge clk);
    got_i = instr_mem_resp;
    got_d = data_mem_resp;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    mem_rdata = $urandom;
    chk("req_clear", 32'({mem_read, mem_write}), 0);
  endtask

  task automatic instr_req(input logic [31:0] addr, input logic [31:0] rexp);
    int n;
    iq.push_back(rexp);
    instr_mem_address = addr;
    instr_read = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!instr_mem_resp && n < 60);
    if (n >= 60) chk("i_timeout", 1, 0);
    @(posedge clk); #1;
    instr_read = 1'b0;
  endtask

  task automatic data_req(input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] rexp);
    int n;
    dq.push_back(rexp);
    data_write = wr;
    data_read = !wr;
    data_mem_address = addr;
    data_mbe = be;
    data_mem_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_mem_resp && n < 60);
    if (n >= 60) chk("d_timeout", 1, 0);
    @(posedge clk); #1;
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, td1, tr1, td2, tr2, n;
    logic gi, gd, gi2, gd2;

    rst = 1'b0;
    instr_read = 0; instr_mem_address = 0;
    data_read = 0; data_write = 0; data_mbe = 0;
    data_mem_address = 0; data_mem_wdata = 0;
    mem_resp = 0; mem_rdata = 32'h1234ABCD;

    // reset values
    @(negedge clk);
    chk("rst_rw", 32'({mem_read, mem_write}), 0);
    chk("rst_be", 32'(mem_byte_enable), 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_resp", 32'({instr_mem_resp, data_mem_resp}), 0);
    chk("rst_ig", instr_grants, 0);
    chk("rst_dg", data_grants, 0);
    chk("rst_irdata", instr_mem_rdata, 32'h1234ABCD);
    chk("rst_drdata", data_mem_rdata, 32'h1234ABCD);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // single fetch, memory latency 3
    t0 = cyc;
    fork
      instr_req(32'h6000_0000, 32'h00A0_0093);
      serve(3, 32'h00A0_0093, 1, 32'h6000_0000, 4'hF, 0, td1, tr1, gi, gd);
    join
    exp_ig++;
    chk("fetch_lat", 32'(td1 - t0), 1);
    chk("fetch_iresp", 32'({gi, gd}), 32'b10);
    chk("fetch_ig", instr_grants, 32'(exp_ig));

    // store path
    fork
      data_req(1, 32'h1000, 4'b0011, 32'h0000_BEEF, 32'h0);
      serve(2, 32'h0, 0, 32'h1000, 4'b0011, 32'h0000_BEEF,
            td1, tr1, gi, gd);
    join
    exp_dg++;
    chk("store_resp", 32'({gi, gd}), 32'b01);
    chk("store_dg", data_grants, 32'(exp_dg));

    // simultaneous requests; last grant was data
    fork
      instr_req(32'h6000_0004, 32'h1111_1111);
      data_req(0, 32'h2000, 4'hF, 0, 32'h2222_2222);
      begin
`ifdef OOO_MEM_ARB_RR_EN
        serve(2, 32'h1111_1111, 1, 32'h6000_0004, 4'hF, 0,
              td1, tr1, gi, gd);
        serve(2, 32'h2222_2222, 1, 32'h2000, 4'hF, 0,
              td2, tr2, gi2, gd2);
        chk("sim_first", 32'({gi, gd}), 32'b10);
        chk("sim_second", 32'({gi2, gd2}), 32'b01);
`else
        serve(2, 32'h2222_2222, 1, 32'h2000, 4'hF, 0,
              td1, tr1, gi, gd);
        serve(2, 32'h1111_1111, 1, 32'h6000_0004, 4'hF, 0,
              td2, tr2, gi2, gd2);
        chk("sim_first", 32'({gi, gd}), 32'b01);
        chk("sim_second", 32'({gi2, gd2}), 32'b10);
`endif
        chk("sim_bubble", 32'(td2 - tr1), 2);
      end
    join
    exp_ig++; exp_dg++;
    chk("sim_ig", instr_grants, 32'(exp_ig));
    chk("sim_dg", data_grants, 32'(exp_dg));

    // back-to-back fetches, latency 1
    fork
      begin
        iq.push_back(32'hAAAA_0001);
        iq.push_back(32'hBBBB_0002);
        instr_mem_address = 32'h6000_0010;
        instr_read = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!instr_mem_resp && n < 60);
        @(posedge clk); #1;
        instr_mem_address = 32'h6000_0014;
        n = 0;
        do begin @(negedge clk); n++; end
        while (!instr_mem_resp && n < 60);
        if (n >= 60) chk("b2b_timeout", 1, 0);
        @(posedge clk); #1;
        instr_read = 1'b0;
      end
      begin
        serve(1, 32'hAAAA_0001, 1, 32'h6000_0010, 4'hF, 0,
              td1, tr1, gi, gd);
        serve(1, 32'hBBBB_0002, 1, 32'h6000_0014, 4'hF, 0,
              td2, tr2, gi2, gd2);
      end
    join
    exp_ig += 2;
    chk("b2b_bubble", 32'(td2 - tr1), 2);
    chk("b2b_lat1", 32'(tr1 - td1), 0);
    chk("b2b_ig", instr_grants, 32'(exp_ig));

    // cancelled fetch
    fork
      begin
        instr_mem_address = 32'h6000_0008;
        instr_read = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end
        while (!mem_read && n < 50);
        @(posedge clk); #1;
        instr_read = 1'b0;
      end
      serve(3, 32'hDEAD_BEEF, 1, 32'h6000_0008, 4'hF, 0,
            td1, tr1, gi, gd);
    join
    exp_ig++;
    chk("cancel_resp", 32'({gi, gd}), 0);
    chk("cancel_ig", instr_grants, 32'(exp_ig));
    @(posedge clk); #1;
    chk("cancel_idle", 32'({mem_read, mem_write}), 0);

    // reset mid-load
    data_read = 1'b1;
    data_mem_address = 32'h3000;
    data_mbe = 4'hF;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!mem_read && n < 50);
    chk("rl_granted", 32'(mem_read), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rl_read_drop", 32'(mem_read), 0);
    chk("rl_ig", instr_grants, 0);
    chk("rl_dg", data_grants, 0);
    data_read = 1'b0;
    exp_ig = 0; exp_dg = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_resp = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("rl_stale", 32'({instr_mem_resp, data_mem_resp}), 0);
    @(posedge clk); #1;
    mem_resp = 1'b0;
    chk("rl_stale_rw", 32'({mem_read, mem_write}), 0);
    chk("rl_stale_dg", data_grants, 0);

    // recovery fetch after reset
    fork
      instr_req(32'h6000_0020, 32'h0C0F_FEE0);
      serve(2, 32'h0C0F_FEE0, 1, 32'h6000_0020, 4'hF, 0,
            td1, tr1, gi, gd);
    join
    exp_ig++;
    chk("rec_ig", instr_grants, 32'(exp_ig));
    chk("rec_dg", data_grants, 32'(exp_dg));

    chk("iq_empty", 32'(iq.size()), 0);
    chk("dq_empty", 32'(dq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
